// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 controller.
//   adc_state_e : controller FSM states
//   ADC_BITS    : sample width returned on SDO
//   CFG_BITS    : config word width shifted out on SDI
//   CFG_*       : bit positions inside the {S/D, O/S, S1, S0, UNI, SLP} word
//   cfg_bit()   : config bit to present on SDI for a given SCK period index
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } adc_state_e;

  localparam int ADC_BITS = 12;
  localparam int CFG_BITS = 6;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  // Period idx carries cfg MSB-first; past the last config bit SDI is held low.
  function automatic logic cfg_bit(input logic [CFG_BITS-1:0] c, input logic [3:0] idx);
    logic [3:0] pos;
    pos = 4'(CFG_SD) - idx;
    return (idx < 4'(CFG_BITS)) ? c[pos[2:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK divider for the LTC2308 serial port.
//   clk, reset_n : system clock, async active-low reset
//   en           : high only while the controller is shifting; low clears the divider
//   sck          : serial clock, CLK_DIV cycles low then CLK_DIV cycles high, starts low
//   rise_tick    : high in the cycle in which sck has just gone 0->1
//   fall_tick    : high in the last cycle of a high phase (sck drops at the end of it)
module adc_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       sck_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      sck   <= 1'b0;
      sck_d <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      sck   <= 1'b0;
      sck_d <= 1'b0;
    end else begin
      sck_d <= sck;
      if (cnt == LAST) begin
        cnt <= '0;
        sck <= ~sck;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign rise_tick = en & sck & ~sck_d;
  // Flagged one cycle early so the period counter and SDI advance on the same
  // edge that drops sck, and the last period can hand straight over to DONE.
  assign fall_tick = en & sck & (cnt == LAST);

endmodule

// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 conversion controller: CONVST pulse, 12 SCK periods, config out on
// SDI, sample in on SDO.
//   clk, reset_n    : 50 MHz clock, async active-low reset
//   start, cfg      : conversion request (IDLE only) and 6-bit config word
//   busy            : conversion in progress, through the data_valid cycle
//   data_valid/data : one-cycle result strobe / last sample (held)
//   adc_convst, adc_sck, adc_sdi, adc_sdo : ADC pins
// The returned sample belongs to the previous conversion's cfg (ADC pipeline).
module adc_ltc2308_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CFG_BITS-1:0] cfg,
  output logic                busy,
  output logic                data_valid,
  output logic [ADC_BITS-1:0] data,
  output logic                adc_convst,
  output logic                adc_sck,
  output logic                adc_sdi,
  input  logic                adc_sdo
);

  adc_state_e          state, state_nxt;
  logic [9:0]          conv_cnt;
  logic [3:0]          bit_cnt;   // completed SCK periods
  logic [ADC_BITS-1:0] sreg, sreg_nxt;
  logic [CFG_BITS-1:0] cfg_q;
  logic                rise_tick, fall_tick;

  adc_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (state == ST_SHIFT),
    .sck       (adc_sck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // SDO is unsynchronized; it is only looked at on rise ticks, where the ADC
  // has had a full low phase to settle it.
  assign sreg_nxt = rise_tick ? {sreg[ADC_BITS-2:0], adc_sdo} : sreg;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CONV;
      ST_CONV:  if (conv_cnt == 10'(CONV_CYCLES - 1)) state_nxt = ST_SHIFT;
      ST_SHIFT: if (fall_tick && bit_cnt == 4'(ADC_BITS - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      conv_cnt <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      cfg_q    <= '0;
      data     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) cfg_q <= cfg;
      conv_cnt <= (state == ST_CONV) ? conv_cnt + 10'd1 : '0;
      if (state != ST_SHIFT)  bit_cnt <= '0;
      else if (fall_tick)     bit_cnt <= bit_cnt + 4'd1;
      sreg <= (state == ST_SHIFT) ? sreg_nxt : '0;
      // Load on DONE entry; sreg_nxt covers CLK_DIV=1 where the last rise
      // and the final fall tick share a cycle.
      if (state == ST_SHIFT && state_nxt == ST_DONE) data <= sreg_nxt;
    end
  end

  assign busy       = (state != ST_IDLE);
  assign data_valid = (state == ST_DONE);
  assign adc_convst = (state == ST_CONV);
  assign adc_sdi    = (state == ST_SHIFT) ? cfg_bit(cfg_q, bit_cnt) : 1'b0;

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
module tb_adc_ltc2308_ctrl;

  typedef struct {
    logic [11:0] data;
    int          cyc;
    logic [11:0] sdi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          cyc = 0;

  // instance a: defaults
  logic        start, busy, dv, convst, sck, sdi, sdo;
  logic [5:0]  cfg;
  logic [11:0] data;
  // instance b: CLK_DIV=1, CONV_CYCLES=2
  logic        start_b, busy_b, dv_b, convst_b, sck_b, sdi_b, sdo_b;
  logic [5:0]  cfg_b;
  logic [11:0] data_b;

  exp_t        exp_q[$], exp_qb[$];
  logic [11:0] word_q[$], word_qb[$];
  logic [11:0] word_cur = '0, word_cur_b = '0;
  int          sdo_idx = 0, sdo_idx_b = 0;

  int          s_tot = 0, s_bad = 0;   // stimulus-side checks
  int          m_tot = 0, m_bad = 0;   // monitor a
  int          b_tot = 0, b_bad = 0;   // monitor b

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_ltc2308_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cfg(cfg), .busy(busy),
    .data_valid(dv), .data(data), .adc_convst(convst), .adc_sck(sck),
    .adc_sdi(sdi), .adc_sdo(sdo)
  );

  adc_ltc2308_ctrl #(.CLK_DIV(1), .CONV_CYCLES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .cfg(cfg_b), .busy(busy_b),
    .data_valid(dv_b), .data(data_b), .adc_convst(convst_b), .adc_sck(sck_b),
    .adc_sdi(sdi_b), .adc_sdo(sdo_b)
  );

  // ADC SDO models: MSB ready after CONVST, next bit after each SCK fall.
  always @(posedge convst or negedge sck)
    if (convst) begin
      if (word_q.size() > 0) word_cur = word_q.pop_front();
      sdo_idx = 0;
    end else sdo_idx++;
  assign sdo = (sdo_idx < 12) ? word_cur[11 - sdo_idx] : 1'b0;

  always @(posedge convst_b or negedge sck_b)
    if (convst_b) begin
      if (word_qb.size() > 0) word_cur_b = word_qb.pop_front();
      sdo_idx_b = 0;
    end else sdo_idx_b++;
  assign sdo_b = (sdo_idx_b < 12) ? word_cur_b[11 - sdo_idx_b] : 1'b0;

  // ---------------- monitor a ----------------
  logic        prev_sck = 0, prev_dv = 0;
  int          conv_run = 0, rise_n = 0, last_rise = 0;
  logic [11:0] sdi_cap = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_sck = 0; prev_dv = 0; conv_run = 0; rise_n = 0;
    end else begin
      m_tot++;
      if (sck && !(busy && !convst && !dv)) begin
        m_bad++; $display("FAIL sck_outside_shift: sck=%0b busy=%0b convst=%0b dv=%0b", sck, busy, convst, dv);
      end
      m_tot++;
      if (convst && sck) begin m_bad++; $display("FAIL convst_with_sck: both high at cyc %0d", cyc); end
      m_tot++;
      if (dv && prev_dv) begin m_bad++; $display("FAIL dv_consecutive: dv high twice at cyc %0d", cyc); end
      if (convst) begin conv_run++; rise_n = 0; end
      else if (conv_run != 0) begin
        m_tot++;
        if (conv_run != 80) begin m_bad++; $display("FAIL convst_width: got %0d want 80", conv_run); end
        conv_run = 0;
      end
      if (sck && !prev_sck) begin
        if (rise_n > 0) begin
          m_tot++;   // 4 clk = 80 ns
          if (cyc - last_rise != 4) begin m_bad++; $display("FAIL sck_period: got %0d want 4 clk", cyc - last_rise); end
        end
        rise_n++; last_rise = cyc;
        sdi_cap = {sdi_cap[10:0], sdi};
      end
      if (dv) begin
        m_tot++;
        if (exp_q.size() == 0) begin
          m_bad++; $display("FAIL unexpected_dv: data=%0h at cyc %0d, none expected", data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (data !== e.data || cyc != e.cyc || sdi_cap !== e.sdi || rise_n != 12) begin
            m_bad++;
            $display("FAIL result: data=%0h cyc=%0d sdi=%b rises=%0d want data=%0h cyc=%0d sdi=%b rises=12",
                     data, cyc, sdi_cap, rise_n, e.data, e.cyc, e.sdi);
          end
        end
      end
      prev_sck = sck; prev_dv = dv;
    end
  end

  // ---------------- monitor b ----------------
  logic prev_sck_b = 0;
  int   conv_run_b = 0, rise_nb = 0, last_rise_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_sck_b = 0; conv_run_b = 0; rise_nb = 0;
    end else begin
      if (convst_b) begin conv_run_b++; rise_nb = 0; end
      else if (conv_run_b != 0) begin
        b_tot++;
        if (conv_run_b != 2) begin b_bad++; $display("FAIL b_convst_width: got %0d want 2", conv_run_b); end
        conv_run_b = 0;
      end
      if (sck_b && !prev_sck_b) begin
        if (rise_nb > 0) begin
          b_tot++;
          if (cyc - last_rise_b != 2) begin b_bad++; $display("FAIL b_sck_period: got %0d want 2 clk", cyc - last_rise_b); end
        end
        rise_nb++; last_rise_b = cyc;
      end
      if (dv_b) begin
        b_tot++;
        if (exp_qb.size() == 0) begin
          b_bad++; $display("FAIL b_unexpected_dv: data=%0h at cyc %0d, none expected", data_b, cyc);
        end else begin
          e = exp_qb.pop_front();
          if (data_b !== e.data || cyc != e.cyc || rise_nb != 12) begin
            b_bad++;
            $display("FAIL b_result: data=%0h cyc=%0d rises=%0d want data=%0h cyc=%0d rises=12",
                     data_b, cyc, rise_nb, e.data, e.cyc);
          end
        end
      end
      prev_sck_b = sck_b;
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
    s_tot++;
    if (act !== want) begin s_bad++; $display("FAIL %s: got %0h want %0h", name, act, want); end
  endtask

  // Caller must be at a negedge with the DUT idle.
  task automatic issue(input logic [5:0] c, input logic [11:0] w);
    word_q.push_back(w);
    exp_q.push_back('{data: w, cyc: cyc + 129, sdi: {c, 6'b0}});
    cfg = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && exp_qb.size() == 0) break;
      @(negedge clk);
    end
    s_tot++;
    if (exp_q.size() != 0 || exp_qb.size() != 0) begin
      s_bad++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, want 0", exp_q.size(), exp_qb.size());
      exp_q.delete(); exp_qb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, r, busy_lo;
    logic ps;
    reset_n = 1'b0; start = 1'b0; cfg = '0; start_b = 1'b0; cfg_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   12'(busy),   12'h0);
    chk("rst_dv",     12'(dv),     12'h0);
    chk("rst_convst", 12'(convst), 12'h0);
    chk("rst_sck",    12'(sck),    12'h0);
    chk("rst_sdi",    12'(sdi),    12'h0);
    chk("rst_data",   data,        12'h000);

    // basic conversion, start on the first clock after release
    reset_n = 1'b1;
    issue(6'b100010, 12'hA5C);
    drain();

    // held start: 390 cycles cover exactly three back-to-back conversions
    n = cyc;
    cfg = 6'b010101;
    word_q.push_back(12'h001); word_q.push_back(12'hFFF); word_q.push_back(12'h800);
    exp_q.push_back('{data: 12'h001, cyc: n + 129, sdi: 12'b010101_000000});
    exp_q.push_back('{data: 12'hFFF, cyc: n + 259, sdi: 12'b010101_000000});
    exp_q.push_back('{data: 12'h800, cyc: n + 389, sdi: 12'b010101_000000});
    start = 1'b1;
    repeat (390) @(negedge clk);
    start = 1'b0;
    drain();

    // start pulses during CONV and SHIFT are ignored, busy stays high
    n = cyc;
    cfg = 6'b001100;
    word_q.push_back(12'h5A5);
    exp_q.push_back('{data: 12'h5A5, cyc: n + 129, sdi: 12'b001100_000000});
    start = 1'b1;
    busy_lo = 0;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      start = (i == 20 || i == 100);
      if (!busy) busy_lo++;
    end
    start = 1'b0;
    chk("busy_continuous", 12'(busy_lo), 12'h0);
    drain();
    repeat (140) @(negedge clk);   // any queued conversion would surface here

    // reset at the 6th SCK rise aborts the conversion
    word_q.push_back(12'h777);
    cfg = 6'b110011; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r = 0; ps = 1'b0;
    for (int i = 0; i < 200 && r < 6; i++) begin
      @(posedge clk); #1;
      if (sck && !ps) r++;
      ps = sck;
    end
    chk("sck_rises_before_reset", 12'(r), 12'd6);
    reset_n = 1'b0;
    #1;
    chk("abort_busy",   12'(busy),   12'h0);
    chk("abort_dv",     12'(dv),     12'h0);
    chk("abort_convst", 12'(convst), 12'h0);
    chk("abort_sck",    12'(sck),    12'h0);
    chk("abort_sdi",    12'(sdi),    12'h0);
    chk("abort_data",   data,        12'h000);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_data", data, 12'h000);
    issue(6'b100010, 12'h3C3);
    drain();

    // fast instance: SCK period 2 clk, result 27 cycles after accept
    word_qb.push_back(12'h3C3);
    exp_qb.push_back('{data: 12'h3C3, cyc: cyc + 27, sdi: 12'h0});
    cfg_b = 6'b000001; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    drain();
    chk("b_data_held", data_b, 12'h3C3);

    $display("test done: total=%0d bad=%0d", s_tot + m_tot + b_tot, s_bad + m_bad + b_bad);
    $finish;
  end

endmodule
